// File: rtl/ram2_port_arbiter.sv
// Shares RAM2's write port and read port 0 between two requesters with per-port round-robin.
// Latency: write grant->wen 1 cycle; read grant->rd_valid 1+RD_LAT cycles; 1 op/cycle per port.
// Backpressure: none queued; an ungranted requester holds its request until its grant bit rises.
module ram2_port_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    wr_req,
    input  logic [AW-1:0] wr_addr0,
    input  logic [AW-1:0] wr_addr1,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    output logic [1:0]    wr_gnt,
    input  logic [1:0]    rd_req,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    output logic [1:0]    rd_gnt,
    output logic [1:0]    rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wen,
    output logic [AW-1:0] raddr0,
    input  logic [DW-1:0] rdata0,
    output logic [15:0]   conflicts
);

    // ptr=0 favours requester 0 under contention, ptr=1 favours requester 1
    logic wr_ptr;
    logic rd_ptr;

    // Tag pipe: stage 0 lines up with raddr0, stage RD_LAT with rdata0
    logic [RD_LAT:0] tag_v;
    logic [RD_LAT:0] tag_id;

    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Grants are suppressed while reset is asserted so nothing is acknowledged then dropped
    always_comb begin
        wr_gnt = 2'b00;
        rd_gnt = 2'b00;
        if (rst) begin
            wr_gnt = rr_pick(wr_req, wr_ptr);
            rd_gnt = rr_pick(rd_req, rd_ptr);
        end
    end

    assign rd_valid = {tag_v[RD_LAT] & tag_id[RD_LAT], tag_v[RD_LAT] & ~tag_id[RD_LAT]};
    assign rd_data  = rdata0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            raddr0    <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
            conflicts <= '0;
        end else begin
            wen <= |wr_gnt;
            if (wr_gnt[0]) begin
                waddr  <= wr_addr0;
                wdata  <= wr_data0;
                wr_ptr <= 1'b1;
            end else if (wr_gnt[1]) begin
                waddr  <= wr_addr1;
                wdata  <= wr_data1;
                wr_ptr <= 1'b0;
            end

            if (rd_gnt[0]) begin
                raddr0 <= rd_addr0;
                rd_ptr <= 1'b1;
            end else if (rd_gnt[1]) begin
                raddr0 <= rd_addr1;
                rd_ptr <= 1'b0;
            end
            tag_v  <= {tag_v[RD_LAT-1:0], |rd_gnt};
            tag_id <= {tag_id[RD_LAT-1:0], rd_gnt[1]};

            if (((wr_req == 2'b11) || (rd_req == 2'b11)) && (conflicts != 16'hFFFF))
                conflicts <= conflicts + 16'd1;
        end
    end

endmodule
